// File: rtl/reaction_delay_timer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : reaction_delay_timer
//  Description : Random start delay plus player reaction-time measurement.
//                On a rising start_delay the block loads
//                MIN_DELAY + (lfsr_value << SCALE) and counts it down on ms
//                ticks. When the count expires it raises timeout, which the
//                sequencer samples. It then counts reaction time as four BCD
//                digits until stop is pressed or the count saturates at 9999.
//                A stop seen during the delay is latched as too_early.
//  Revision    : 1.0 - initial release
// ============================================================================
module reaction_delay_timer #(
    parameter int LFSR_W    = 7,
    parameter int MIN_DELAY = 500,
    parameter int SCALE     = 4,
    parameter int DELAY_W   = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              start_delay,
    input  logic [LFSR_W-1:0] lfsr_value,
    input  logic              stop,
    output logic              timeout,
    output logic              busy,
    output logic [15:0]       bcd,
    output logic              result_valid,
    output logic              too_early
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_DELAY   = 2'd1;
    localparam logic [1:0] S_MEASURE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic [DELAY_W-1:0] C_MIN_DELAY = DELAY_W'(MIN_DELAY);
    localparam logic [DELAY_W-1:0] C_CNT_ONE   = DELAY_W'(1);
    localparam logic [15:0]        C_BCD_MAX   = 16'h9999;

    // ------------------------------------------------------------------------
    // Registers and combinational next-state values
    // ------------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               r_start_d;
    logic               w_start_rise;

    logic [DELAY_W-1:0] r_delay_cnt;
    logic [DELAY_W-1:0] w_delay_cnt_nxt;
    logic [DELAY_W-1:0] w_delay_load;
    logic [DELAY_W-1:0] w_lfsr_ext;
    logic               w_delay_last;

    logic               r_timeout;
    logic               w_timeout_nxt;
    logic               r_busy;
    logic               w_busy_nxt;
    logic [15:0]        r_bcd;
    logic [15:0]        w_bcd_nxt;
    logic [15:0]        w_bcd_inc;
    logic               r_result_valid;
    logic               w_result_valid_nxt;
    logic               r_too_early;
    logic               w_too_early_nxt;

    // ------------------------------------------------------------------------
    // Cascaded decimal increment: a digit at 9 wraps to 0 and carries on.
    // Saturation at 9999 is handled by the caller, never reached here.
    // ------------------------------------------------------------------------
    function automatic logic [15:0] f_bcd_inc(input logic [15:0] v);
        logic [15:0] res;
        logic        carry;
        res   = v;
        carry = 1'b1;
        for (int d = 0; d < 4; d++) begin
            if (carry) begin
                if (v[d*4 +: 4] == 4'd9) begin
                    res[d*4 +: 4] = 4'd0;
                    carry         = 1'b1;
                end else begin
                    res[d*4 +: 4] = v[d*4 +: 4] + 4'd1;
                    carry         = 1'b0;
                end
            end
        end
        return res;
    endfunction

    // ------------------------------------------------------------------------
    // Start edge detection. The delayed copy resets to 1 so that a start
    // level already high when reset is released is not taken as a new start.
    // ------------------------------------------------------------------------
    assign w_start_rise = start_delay & ~r_start_d;

    // Delay load value, zero-extending lfsr_value before the shift so no
    // high bits are lost.
    assign w_lfsr_ext   = {{(DELAY_W-LFSR_W){1'b0}}, lfsr_value};
    assign w_delay_load = C_MIN_DELAY + (w_lfsr_ext << SCALE);

    // Last tick of the delay: this tick brings the count from 1 to 0.
    assign w_delay_last = tick && (r_delay_cnt == C_CNT_ONE);

    assign w_bcd_inc    = f_bcd_inc(r_bcd);

    // Register the start_delay level for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_start_d <= 1'b1;
        end else begin
            r_start_d <= start_delay;
        end
    end

    // ------------------------------------------------------------------------
    // FSM process 1: state register.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM process 2: next-state logic. A start edge restarts from any state.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (w_start_rise) begin
            w_state_nxt = S_DELAY;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_IDLE;
                end
                S_DELAY: begin
                    // A stop in the expiry cycle itself also counts as early.
                    if (w_delay_last) begin
                        if (r_too_early || stop) begin
                            w_state_nxt = S_DONE;
                        end else begin
                            w_state_nxt = S_MEASURE;
                        end
                    end
                end
                S_MEASURE: begin
                    if (stop) begin
                        w_state_nxt = S_DONE;
                    end else if (tick && (r_bcd == C_BCD_MAX)) begin
                        w_state_nxt = S_DONE;
                    end
                end
                S_DONE: begin
                    w_state_nxt = S_DONE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // FSM process 3: output/datapath next values. All outputs are registered
    // below, so this block only decides what they become on the next edge.
    // ------------------------------------------------------------------------
    always_comb begin
        w_delay_cnt_nxt    = r_delay_cnt;
        w_bcd_nxt          = r_bcd;
        w_timeout_nxt      = r_timeout;
        w_result_valid_nxt = r_result_valid;
        w_too_early_nxt    = r_too_early;

        if (w_start_rise) begin
            // lfsr_value is only sampled here; a tick in this cycle is ignored.
            w_delay_cnt_nxt    = w_delay_load;
            w_bcd_nxt          = 16'h0000;
            w_timeout_nxt      = 1'b0;
            w_result_valid_nxt = 1'b0;
            w_too_early_nxt    = 1'b0;
        end else begin
            case (r_state)
                S_DELAY: begin
                    if (stop) begin
                        w_too_early_nxt = 1'b1;
                    end
                    if (tick) begin
                        w_delay_cnt_nxt = r_delay_cnt - C_CNT_ONE;
                    end
                    if (w_delay_last) begin
                        // timeout is a level: the sequencer only looks on ticks.
                        w_timeout_nxt = 1'b1;
                        if (r_too_early || stop) begin
                            w_result_valid_nxt = 1'b1;
                            w_bcd_nxt          = 16'h0000;
                        end
                    end
                end
                S_MEASURE: begin
                    // stop beats a coincident tick, which is then not counted.
                    if (stop) begin
                        w_result_valid_nxt = 1'b1;
                    end else if (tick) begin
                        if (r_bcd == C_BCD_MAX) begin
                            w_result_valid_nxt = 1'b1;
                        end else begin
                            w_bcd_nxt = w_bcd_inc;
                        end
                    end
                end
                default: begin
                    // IDLE and DONE hold everything.
                end
            endcase
        end

        w_busy_nxt = (w_state_nxt == S_DELAY) || (w_state_nxt == S_MEASURE);
    end

    // Register the datapath and all outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_delay_cnt    <= '0;
            r_bcd          <= 16'h0000;
            r_timeout      <= 1'b0;
            r_busy         <= 1'b0;
            r_result_valid <= 1'b0;
            r_too_early    <= 1'b0;
        end else begin
            r_delay_cnt    <= w_delay_cnt_nxt;
            r_bcd          <= w_bcd_nxt;
            r_timeout      <= w_timeout_nxt;
            r_busy         <= w_busy_nxt;
            r_result_valid <= w_result_valid_nxt;
            r_too_early    <= w_too_early_nxt;
        end
    end

    assign timeout      = r_timeout;
    assign busy         = r_busy;
    assign bcd          = r_bcd;
    assign result_valid = r_result_valid;
    assign too_early    = r_too_early;

endmodule
`default_nettype wire
